// File: rtl/mips_cpu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair; also MTHI/MTLO.
// Ports: clk, reset_n, start, funct, rs_content, rt_content -> busy, done, hi, lo.
module mips_cpu_muldiv (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_content,
  input  logic [31:0] rt_content,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [5:0]  cnt;
  logic        is_div;
  logic        neg_p;
  logic        neg_r;
  logic        div_zero;
  logic [31:0] opb;
  logic [63:0] acc;

  logic        op_mul;
  logic        op_div;
  logic        op_sgn;
  logic        op_mthi;
  logic        op_mtlo;

  always_comb begin
    op_mul  = 1'b0;
    op_div  = 1'b0;
    op_sgn  = 1'b0;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    unique case (1'b1)
      funct == F_MULT:  begin op_mul = 1'b1; op_sgn = 1'b1; end
      funct == F_MULTU: op_mul = 1'b1;
      funct == F_DIV:   begin op_div = 1'b1; op_sgn = 1'b1; end
      funct == F_DIVU:  op_div = 1'b1;
      funct == F_MTHI:  op_mthi = 1'b1;
      funct == F_MTLO:  op_mtlo = 1'b1;
      default: ;
    endcase
  end

  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;

  assign rs_neg = op_sgn & rs_content[31];
  assign rt_neg = op_sgn & rt_content[31];
  assign rs_mag = rs_neg ? -rs_content : rs_content;
  assign rt_mag = rt_neg ? -rt_content : rt_content;

  // acc holds {partial, multiplier} for multiply and
  // {remainder, dividend/quotient} for divide.
  logic [32:0] mul_sum;
  logic [63:0] mul_nx;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_df;
  logic [63:0] div_nx;
  logic [63:0] step_nx;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        last;

  assign mul_sum = {1'b0, acc[63:32]}
                 + {1'b0, acc[0] ? opb : 32'd0};
  assign mul_nx  = {mul_sum, acc[31:1]};

  // Remainder stays below the divisor, so the difference fits 32 bits.
  assign div_sh  = acc[63:31];
  assign div_ge  = div_sh >= {1'b0, opb};
  assign div_df  = div_sh[31:0] - opb;
  assign div_nx  = {div_ge ? div_df : div_sh[31:0],
                    acc[30:0], div_ge};

  assign step_nx = is_div ? div_nx : mul_nx;
  assign prod    = neg_p ? -step_nx : step_nx;
  assign quo     = step_nx[31:0];
  assign rem     = step_nx[63:32];

  // With a zero divisor the remainder is |rs|; restoring its sign
  // gives back the original rs, so only the quotient is forced.
  assign res_lo  = !is_div  ? prod[31:0] :
                   div_zero ? 32'hFFFF_FFFF :
                   neg_p    ? -quo : quo;
  assign res_hi  = !is_div  ? prod[63:32] :
                   neg_r    ? -rem : rem;

  assign last = cnt == 6'd31;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: if (start && (op_mul || op_div)) state_nx = S_CALC;
      S_CALC: begin
        busy = 1'b1;
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      opb      <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_p    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start && (op_mul || op_div)) begin
            is_div   <= op_div;
            neg_p    <= rs_neg ^ rt_neg;
            neg_r    <= rs_neg;
            div_zero <= rt_content == 32'd0;
            cnt      <= '0;
            opb      <= op_div ? rt_mag : rs_mag;
            acc      <= {32'd0, op_div ? rs_mag : rt_mag};
          end else if (start && op_mthi) begin
            hi <= rs_content;
          end else if (start && op_mtlo) begin
            lo <= rs_content;
          end
        end
        S_CALC: begin
          acc <= step_nx;
          cnt <= cnt + 6'd1;
          if (last) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mips_cpu_muldiv.md
# mips_cpu_muldiv

Iterative multiply/divide unit owning the HI/LO register pair. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO for the MIPS core. It sits beside the single-cycle ALU in the execute stage and receives the same rs/rt operand buses and R-type funct field. The datapath muxes `hi`/`lo` directly for MFHI/MFLO and stalls the core while `busy` is high.

## Interface
Parameters:
- none; the width is fixed at 32 bits.

Ports:
- `clk`  in  1  Clock. All registers update on the rising edge.
- `reset_n`  in  1  Asynchronous, active-low reset.
- `start`  in  1  Request qualifier. Only sampled while in IDLE.
- `funct`  in  6  R-type funct code:
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU
  - 0x11 MTHI, 0x13 MTLO
  - all other codes are ignored.
- `rs_content`  in  32  Multiplicand, dividend, or MT source.
- `rt_content`  in  32  Multiplier or divisor.
- `busy`  out  1  High in CALC. The core stalls on it.
- `done`  out  1  One-cycle pulse in DONE.
- `hi`  out  32  HI register, read by MFHI.
- `lo`  out  32  LO register, read by MFLO.

## Operation
- **States:**
  - IDLE: `busy`=0, `done`=0.
  - CALC: `busy`=1, `done`=0.
  - DONE: `busy`=0, `done`=1.
- **Accept:** in IDLE with `start`=1, on the clock edge:
  - MULT/MULTU/DIV/DIVU: latch operands, signedness and op type, clear the 6-bit iteration counter, go to CALC.
  - MTHI: `hi`<=`rs_content`. MTLO: `lo`<=`rs_content`. State stays IDLE.
  - Unknown funct: no effect.
- **Operand latching:** for signed ops, latch magnitudes (two's-complement abs) and record the result signs.
  - Product sign = rs[31]^rt[31].
  - Quotient sign = rs[31]^rt[31].
  - Remainder sign = rs[31].
  - Unsigned ops latch raw values with positive signs.
- **Multiply:** shift-add over a 64-bit accumulator, one multiplier bit per cycle, 32 iterations.
- **Divide:** restoring divide with a 33-bit partial remainder, one quotient bit per cycle, 32 iterations.
- **CALC exit:** on the 32nd CALC edge, write the sign-corrected result into `hi`/`lo` and go to DONE.
  - Multiply: {hi,lo} = 64-bit product.
  - Divide: lo = quotient, hi = remainder.
- **DONE:** goes to IDLE unconditionally on the next edge. `start` is not sampled in DONE.
- **Divide by zero** (rt latched == 0, signed or unsigned): after full latency, `lo`=0xFFFFFFFF and `hi`=original `rs_content`.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0. This is the natural result of magnitude arithmetic truncated to 32 bits.
- **Requests while busy:** `start` in CALC or DONE is ignored, including MTHI/MTLO. `hi`/`lo` are not disturbed until the result write.
- **Operand stability:** changes on `rs_content`/`rt_content` after accept have no effect on the result.

## Timing
- **Reset:** `reset_n`=0 asynchronously forces:
  - state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
  - Reset mid-CALC aborts the operation and writes no result.
- **Latency:**
  - Accept edge E0 begins CALC in cycle 1.
  - `busy`=1 for cycles 1–32.
  - `hi`/`lo` update at edge E32.
  - `done`=1 in cycle 33.
  - IDLE again in cycle 34, so the earliest next accept is edge E34.
- **MTHI/MTLO:** single cycle. The new value is visible on `hi`/`lo` the cycle after the accept edge.
- **Output reads:** `hi`/`lo` are registered outputs and hold their value in every state except at the result write.

## Test plan
- **MULTU:** rs=0xFFFFFFFF, rt=0xFFFFFFFF.
  - Required: `busy` high exactly 32 cycles, `done` pulse in cycle 33, `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **MULT (signed):**
  - −3 × 7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
  - 0x80000000 × 0x80000000 -> `hi`=0x40000000, `lo`=0.
- **DIV (signed):**
  - −7 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- **DIVU:**
  - 100 / 7 -> `lo`=14, `hi`=2.
  - 7 / 0 -> `lo`=0xFFFFFFFF, `hi`=7, with the same 33-cycle latency.
- **MT ops and busy blocking:**
  - MTHI 0x12345678 in IDLE -> `hi` updates next cycle with no `busy`.
  - MTLO issued during CALC -> ignored; the result write wins.
  - Changing rs/rt mid-CALC -> result unchanged.
- **Reset abort:** deassert `reset_n` in cycle 10 of a MULTU.
  - Required: immediately `busy`=0, `hi`=`lo`=0, and no `done` pulse.
  - After release, a fresh DIVU 9/3 gives `lo`=3, `hi`=0.
